// File: rtl/twisted_ring_counter.sv
// twisted_ring_counter: Johnson/ring shift counter with load, wrap pulse, optional SELF_CORRECT_EN recovery
module twisted_ring_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             err
);
    logic             mode_q;
    logic             bad;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] sp_in;
    logic [WIDTH-1:0] sp_q;
    always_comb begin
        sp_in = mode ? WIDTH'(1) : '0;
        sp_q  = mode_q ? WIDTH'(1) : '0;
        nxt   = dir ? {out[WIDTH-2:0], mode_q ? out[WIDTH-1] : ~out[WIDTH-1]}
                    : {mode_q ? out[0] : ~out[0], out[WIDTH-1:1]};
    end
`ifdef SELF_CORRECT_EN
    // Johnson legal: at most one adjacent-bit transition; ring legal: exactly one bit set
    logic [WIDTH-2:0] tr;
    assign tr  = out[WIDTH-1:1] ^ out[WIDTH-2:0];
    assign bad = mode_q ? (out == '0 || (out & (out - WIDTH'(1))) != '0)
                        : ((tr & (tr - (WIDTH-1)'(1))) != '0);
`else
    assign bad = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= sp_in;
            mode_q <= mode;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (load) begin
                out <= load_val;
            end else if (mode != mode_q) begin
                out    <= sp_in;
                mode_q <= mode;
            end else if (en) begin
                out  <= bad ? sp_q : nxt;
                err  <= bad;
                wrap <= !bad && nxt == sp_q;
            end
        end
    end
endmodule

// File: tb/tb_twisted_ring_counter.sv
// tb_twisted_ring_counter: directed checks of the WIDTH=8 twisted_ring_counter
module tb_twisted_ring_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] out;
    logic       wrap;
    logic       err;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] jd [17] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                            8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    logic [7:0] ju [17] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                            8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

    twisted_ring_counter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .out(out), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({out, wrap, err} !== {8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset out=%h wrap=%b err=%b expected 00/0/0", out, wrap, err);
        end
    endtask

    task automatic test_johnson_down();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++;
            if (out !== jd[i] || wrap !== (i == 16)) begin
                n_bad++;
                $display("FAIL johnson_down step %0d out=%h wrap=%b expected %h/%b", i, out, wrap, jd[i], i == 16);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_johnson_up();
        rst = 1'b1; mode = 1'b0;
        tick();
        rst = 1'b0; dir = 1'b1; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++;
            if (out !== ju[i] || wrap !== (i == 16)) begin
                n_bad++;
                $display("FAIL johnson_up step %0d out=%h wrap=%b expected %h/%b", i, out, wrap, ju[i], i == 16);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_ring();
        logic [7:0] e;
        mode = 1'b1; en = 1'b1; dir = 1'b0;
        tick();
        n_cmp++;
        if (out !== 8'h01 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL ring_mode_change out=%h wrap=%b expected 01/0", out, wrap);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = 8'h80 >> (i - 1);
            n_cmp++;
            if (out !== e || wrap !== (i == 8)) begin
                n_bad++;
                $display("FAIL ring step %0d out=%h wrap=%b expected %h/%b", i, out, wrap, e, i == 8);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_illegal_load();
        mode = 1'b0; en = 1'b0;
        tick();
        load = 1'b1; load_val = 8'h5A;
        tick();
        load = 1'b0;
        n_cmp++;
        if (out !== 8'h5A || err !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_load out=%h err=%b wrap=%b expected 5a/0/0", out, err, wrap);
        end
        tick();
        n_cmp++;
        if (out !== 8'h5A || err !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_hold out=%h err=%b expected 5a/0", out, err);
        end
        en = 1'b1; dir = 1'b0;
        tick();
`ifdef SELF_CORRECT_EN
        n_cmp++;
        if (out !== 8'h00 || err !== 1'b1 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_step out=%h err=%b wrap=%b expected 00/1/0", out, err, wrap);
        end
        tick();
        n_cmp++;
        if (out !== 8'h80 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_after out=%h err=%b expected 80/0", out, err);
        end
`else
        n_cmp++;
        if (out !== 8'hAD || err !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_step out=%h err=%b wrap=%b expected ad/0/0", out, err, wrap);
        end
        tick();
        n_cmp++;
        if (out !== 8'h56 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_after out=%h err=%b expected 56/0", out, err);
        end
`endif
        en = 1'b0;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; mode = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; dir = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (out !== 8'hF0) begin
            n_bad++;
            $display("FAIL rst_pre out=%h expected f0", out);
        end
        rst = 1'b1; load = 1'b1; load_val = 8'hAA; mode = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        n_cmp++;
        if ({out, wrap, err} !== {8'h01, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_priority out=%h wrap=%b err=%b expected 01/0/0", out, wrap, err);
        end
    endtask

    task automatic test_hold();
        mode = 1'b0; en = 1'b1; dir = 1'b0;
        tick();
        n_cmp++;
        if (out !== 8'h00) begin
            n_bad++;
            $display("FAIL hold_mode_change out=%h expected 00", out);
        end
        repeat (10) tick();
        n_cmp++;
        if (out !== 8'h3F) begin
            n_bad++;
            $display("FAIL hold_pre out=%h expected 3f", out);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dir = ~dir;
            tick();
            n_cmp++;
            if (out !== 8'h3F || wrap !== 1'b0) begin
                n_bad++;
                $display("FAIL hold cycle %0d out=%h wrap=%b expected 3f/0", i, out, wrap);
            end
        end
        en = 1'b1; dir = 1'b0;
        tick();
        en = 1'b0;
        n_cmp++;
        if (out !== 8'h1F) begin
            n_bad++;
            $display("FAIL hold_resume out=%h expected 1f", out);
        end
    endtask

    task automatic test_back_to_back();
        mode = 1'b1; load = 1'b1; load_val = 8'h3C; en = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (out !== 8'h3C) begin
            n_bad++;
            $display("FAIL load_over_mode out=%h expected 3c", out);
        end
        tick();
        n_cmp++;
        if (out !== 8'h01) begin
            n_bad++;
            $display("FAIL deferred_mode out=%h expected 01", out);
        end
        dir = 1'b1;
        tick();
        n_cmp++;
        if (out !== 8'h02 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL ring_up out=%h wrap=%b expected 02/0", out, wrap);
        end
        dir = 1'b0;
        tick();
        en = 1'b0;
        n_cmp++;
        if (out !== 8'h01 || wrap !== 1'b1) begin
            n_bad++;
            $display("FAIL ring_dir_flip out=%h wrap=%b expected 01/1", out, wrap);
        end
        tick();
        n_cmp++;
        if (wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_pulse wrap=%b expected 0", wrap);
        end
    endtask

    initial begin
        test_reset();
        test_johnson_down();
        test_johnson_up();
        test_ring();
        test_illegal_load();
        test_reset_priority();
        test_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
